// File: rtl/modmul_613_pipe.sv
// +--------------------------------------------------------------------------+
// | modmul_613_pipe : 3-stage valid/ready modular multiplier over Z_613,     |
// |                   Barrett reduction of the 19-bit product.  Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module modmul_613_pipe #(
  parameter int Q  = 613,
  parameter int QW = 10,
  parameter int PW = 19,
  parameter int K  = 20,
  parameter int M  = 1710
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] in_a,
  input  logic [QW-1:0] in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] out_r,
  output logic          out_range_err
);

  localparam int TW = QW + 2;
  localparam int MW = $clog2(M + 1);
  localparam int BW = PW + MW;

  localparam logic [QW-1:0] c_Q_RES  = QW'(Q);
  localparam logic [PW-1:0] c_Q_PROD = PW'(Q);
  localparam logic [TW-1:0] c_Q_T    = TW'(Q);
  localparam logic [BW-1:0] c_M      = BW'(M);

  logic            r_v1, r_v2, r_v3;
  logic [PW-1:0]   r_p1;
  logic            r_e1, r_e2, r_e3;
  logic [TW-1:0]   r_t2;
  logic [QW-1:0]   r_r3;

  logic            w_adv1, w_adv2, w_adv3;
  logic [2*QW-1:0] w_full;
  logic [PW-1:0]   w_p;
  logic            w_err;
  logic [BW-1:0]   w_pm;
  logic [BW-K-1:0] w_qh;
  logic [PW-1:0]   w_qq;
  logic [PW-1:0]   w_t;
  logic [TW-1:0]   w_r1, w_r2;
  logic            w_unused_bits;

  // Each stage loads when empty or when its occupant leaves this same cycle.
  assign w_adv3   = !r_v3 || out_ready;
  assign w_adv2   = !r_v2 || w_adv3;
  assign w_adv1   = !r_v1 || w_adv2;
  assign in_ready = w_adv1;

  assign w_full = {{QW{1'b0}}, in_a} * {{QW{1'b0}}, in_b};
  assign w_p    = w_full[PW-1:0];
  assign w_err  = (in_a >= c_Q_RES) || (in_b >= c_Q_RES);

  // Quotient estimate undershoots by at most one, so t stays below 2Q (< 3Q).
  assign w_pm = BW'(r_p1) * c_M;
  assign w_qh = w_pm[BW-1:K];
  assign w_qq = PW'(w_qh) * c_Q_PROD;
  assign w_t  = r_p1 - w_qq;

  assign w_r1 = (r_t2 >= c_Q_T) ? (r_t2 - c_Q_T) : r_t2;
  assign w_r2 = (w_r1 >= c_Q_T) ? (w_r1 - c_Q_T) : w_r1;

  assign w_unused_bits = ^{w_full[2*QW-1:PW], w_pm[K-1:0], w_t[PW-1:TW], w_r2[TW-1:QW]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_p1 <= '0;
      r_e1 <= 1'b0;
      r_t2 <= '0;
      r_e2 <= 1'b0;
      r_r3 <= '0;
      r_e3 <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_v1 <= in_valid;
        if (in_valid) begin
          r_p1 <= w_p;
          r_e1 <= w_err;
        end
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_t2 <= w_t[TW-1:0];
          r_e2 <= r_e1;
        end
      end
      if (w_adv3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_r3 <= w_r2[QW-1:0];
          r_e3 <= r_e2;
        end
      end
    end
  end

  assign out_valid     = r_v3;
  assign out_r         = r_r3;
  assign out_range_err = r_e3;

endmodule

`default_nettype wire

// File: tb/tb_modmul_613_pipe.sv
// Directed bench for modmul_613_pipe: stage-occupancy scoreboard checks
// handshakes, latency, FIFO order and results every cycle.
`default_nettype none
`timescale 1ns/1ps

module tb_modmul_613_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_a;
  logic [9:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_r;
  logic       out_range_err;

  modmul_613_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_r         (out_r),
    .out_range_err (out_range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    bit e;
    int stg;   // stage the item occupies after the coming clock edge
  } item_t;

  item_t q[$];
  int    n_pass  = 0;
  int    n_total = 0;
  int    n_sub1  = 0;
  int    cur_r;
  bit    cur_e;

  function automatic int model_r(input int a, input int b);
    return ((a * b) & 32'h7FFFF) % 613;
  endfunction

  function automatic bit model_e(input int a, input int b);
    return (a >= 613) || (b >= 613);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  // One clock: called just after a negedge with inputs already driven.
  task automatic step(output bit acc);
    bit exp_v;
    bit exp_rdy;
    int lim;
    #1;
    exp_v   = (q.size() > 0) && (q[0].stg == 3);
    exp_rdy = !((q.size() == 3) && !out_ready);
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
    check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    if (exp_v) begin
      check("out_r", {22'b0, out_r}, q[0].r);
      check("out_range_err", {31'b0, out_range_err}, {31'b0, q[0].e});
      if (out_ready) void'(q.pop_front());
    end
    for (int i = 0; i < q.size(); i++) begin
      lim = (i == 0) ? 3 : q[i-1].stg - 1;
      if (q[i].stg < lim) q[i].stg++;
    end
    acc = in_valid && exp_rdy;
    if (acc) q.push_back('{cur_r, cur_e, 1});
    if (dut.r_v2 && (dut.r_t2 >= 12'd613)) n_sub1++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int a, input int b, input int er, input bit ee);
    bit acc;
    int guard;
    in_a     = 10'(a);
    in_b     = 10'(b);
    cur_r    = er;
    cur_e    = ee;
    in_valid = 1'b1;
    acc      = 1'b0;
    guard    = 0;
    while (!acc && guard < 50) begin
      step(acc);
      guard++;
    end
    check("accept", {31'b0, acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int guard;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    guard     = 0;
    while (q.size() > 0 && guard < 20) begin
      step(acc);
      guard++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    bit acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_r", {22'b0, out_r}, 32'd0);
    check("reset_out_err", {31'b0, out_range_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", {31'b0, in_ready}, 32'd1);
    @(negedge clk);

    // Corners with hand-computed results; isolated so the latency is exact.
    send(612, 612, 1, 0);   drain();
    send(0, 437, 0, 0);     drain();
    send(1, 612, 612, 0);   drain();
    send(2, 307, 1, 0);     drain();
    send(0, 0, 0, 0);
    send(612, 611, 2, 0);
    send(612, 2, 611, 0);
    drain();

    // Products around multiples of 613 (612 = 613-1, 614 = 613+1, 1224 = 2*613-2).
    send(2, 306, 612, 0);
    send(3, 204, 612, 0);
    send(4, 153, 612, 0);
    send(611, 612, 2, 0);
    send(612, 612, 1, 0);
    send(2, 307, 1, 0);
    drain();
    check("t_ge_q_seen", {31'b0, n_sub1 > 0}, 32'd1);

    // Out-of-range operand, then a legal pair right behind it.
    send(700, 5, 435, 1);
    send(3, 4, 12, 0);
    drain();

    // Back-to-back partial sweep of the top rows.
    for (int a = 600; a < 613; a++)
      for (int b = 0; b < 613; b++)
        send(a, b, model_r(a, b), 0);
    drain();

    // Random traffic with out_ready high about 30% of the time.
    for (int i = 0; i < 400; i++) begin
      in_a      = 10'($urandom_range(0, 612));
      in_b      = 10'($urandom_range(0, 612));
      cur_r     = model_r(int'(in_a), int'(in_b));
      cur_e     = model_e(int'(in_a), int'(in_b));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 3);
      step(acc);
    end
    drain();

    // Mid-stream reset with three results in flight.
    out_ready = 1'b0;
    send(10, 20, 200, 0);
    send(30, 40, 587, 0);
    send(50, 60, 548, 0);
    check("full_before_reset", q.size(), 3);
    rst = 1'b1;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    out_ready = 1'b1;
    #1;
    check("ready_after_midreset", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    for (int i = 0; i < 6; i++) step(acc);
    send(5, 6, 30, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
